// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide that owns the HI/LO registers.
// Latency: start sampled at E0, HI/LO committed at E32, done pulses in the following cycle.
// Backpressure: busy is high for the 32 iteration cycles; start and MTHI/MTLO are ignored while busy.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working registers: the operation is latched once at start and the
  // 2*WIDTH accumulator carries the partial product or {remainder, quotient}.
  logic               is_div_q,  is_div_d;
  logic               neg_q,     neg_d;      // product / quotient sign
  logic               rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic [WIDTH-1:0]   a_q,       a_d;        // |multiplicand|
  logic [WIDTH-1:0]   b_q,       b_d;        // |divisor| (multiplier lives in acc)
  logic [WIDTH-1:0]   rs_raw_q,  rs_raw_d;   // raw dividend for divide-by-zero
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;

  logic accept;
  logic last_step;

  // A new operation is only taken when no iteration is running.
  assign accept    = start && (state_q != S_RUN);
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST_STEP);

  // Operand conditioning: magnitudes for signed ops, raw values for unsigned.
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign rs_neg = ~op[0] & rs_data[WIDTH-1];
  assign rt_neg = ~op[0] & rt_data[WIDTH-1];
  assign rs_abs = rs_neg ? -rs_data : rs_data;
  assign rt_abs = rt_neg ? -rt_data : rt_data;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_cand;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  // Combinational datapath for the current iteration step.
  always_comb begin
    // Multiply: add |a| into the upper half when the low multiplier bit is set,
    // then shift the whole {carry, upper, lower} right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. The true difference is below b, so
    // the low WIDTH bits of the modular subtraction are exact.
    div_cand = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_cand[WIDTH-1:0] - b_q;
    if (div_cand >= {1'b0, b_q}) begin
      div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    step_next = is_div_q ? div_next : mul_next;
  end

  // Final sign fix-up and the divide-by-zero override, applied at commit.
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   q_mag, r_mag;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Result formatting from the magnitude produced by the last step.
  always_comb begin
    prod_signed = neg_q ? -step_next : step_next;
    q_mag       = step_next[WIDTH-1:0];
    r_mag       = step_next[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      res_hi = prod_signed[2*WIDTH-1:WIDTH];
      res_lo = prod_signed[WIDTH-1:0];
    end else if (b_q == '0) begin
      // Divide by zero still runs the full iteration and returns a fixed pattern.
      res_hi = rs_raw_q;
      res_lo = '1;
    end else begin
      // Truncating division: quotient sign is the xor of operand signs.
      // 0x80000000 / -1 negates nothing and naturally yields 0x80000000.
      res_lo = neg_q     ? -q_mag : q_mag;
      res_hi = rem_neg_q ? -r_mag : r_mag;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE, with DONE able to relaunch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_STEP) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Working-register next state: load on accept, iterate while running.
  always_comb begin
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    a_d       = a_q;
    b_d       = b_q;
    rs_raw_d  = rs_raw_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (accept) begin
      is_div_d  = op[1];
      neg_d     = rs_neg ^ rt_neg;
      rem_neg_d = rs_neg;
      a_d       = rs_abs;
      b_d       = rt_abs;
      rs_raw_d  = rs_data;
      // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
      acc_d     = op[1] ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
      cnt_d     = '0;
    end else if (state_q == S_RUN) begin
      acc_d = step_next;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Working registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rs_raw_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_raw_q  <= rs_raw_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  // HI/LO next state: commit on the last step, else MTHI/MTLO when idle and
  // not launching (a launch on the same edge drops the move).
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (last_step) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if ((state_q != S_RUN) && !start) begin
      if (mthi) hi_d = mt_data;
      if (mtlo) lo_d = mt_data;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a plain-arithmetic reference model.
// Stimulus drives on negedges; a monitor pops expected HI/LO whenever done is seen.
// Directed cases cover the listed corner cases, then a randomized loop with back-to-back issue.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    res = '0;
    case (o)
      2'b00: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = sa * sb;
      end
      2'b01: res = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          sa  = longint'($signed(a));
          sb  = longint'($signed(b));
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hi", hi, mon_e[63:32]);
        check("sb_lo", lo, mon_e[31:0]);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the launch edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    if (push) exp_q.push_back(model(o, a, b));
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Counts busy cycles, checks HI/LO hold, optionally injects ignored start/mtlo.
  task automatic run_check(input int interfere);
    int          n;
    logic [31:0] h0, l0;
    bit          held;
    n    = 0;
    h0   = hi;
    l0   = lo;
    held = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (interfere != 0 && n == interfere) begin
        mtlo    = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd7;
        rt_data = 32'd7;
      end else if (interfere != 0 && n == interfere + 1) begin
        mtlo  = 1'b0;
        start = 1'b0;
      end
      @(negedge CLK);
    end
    check("busy_cycles", 32'(n), 32'd32);
    check("hold_during_run", {31'b0, held}, 32'd1);
    check("done_after_e32", {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;

    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    mt_data = '0;
    repeat (3) @(negedge CLK);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_check(0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(negedge CLK);
    check("done_one_cycle", {31'b0, done}, 32'd0);

    launch(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_check(0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(negedge CLK);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_check(0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    @(negedge CLK);

    launch(2'b11, 32'd100, 32'd0, 1'b1);
    run_check(0);
    check("div0_hi", hi, 32'h0000_0064);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    @(negedge CLK);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_check(0);
    check("ovf_hi", hi, 32'h0);
    check("ovf_lo", lo, 32'h8000_0000);
    @(negedge CLK);

    mthi    = 1'b1;
    mt_data = 32'h1234_5678;
    @(negedge CLK);
    mthi = 1'b0;
    check("mthi_idle", hi, 32'h1234_5678);

    launch(2'b01, 32'd3, 32'd4, 1'b1);
    run_check(5);
    check("ignored_hi", hi, 32'h0);
    check("ignored_lo", lo, 32'd12);
    @(negedge CLK);

    mthi    = 1'b1;
    mt_data = 32'h0000_AAAA;
    @(negedge CLK);
    mthi    = 1'b0;
    mtlo    = 1'b1;
    mt_data = 32'h0000_5555;
    @(negedge CLK);
    mtlo = 1'b0;
    check("pre_reset_hi", hi, 32'h0000_AAAA);
    check("pre_reset_lo", lo, 32'h0000_5555);

    launch(2'b01, 32'd12345, 32'd6789, 1'b0);
    repeat (9) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("midrun_reset_hi", hi, 32'h0);
    check("midrun_reset_lo", lo, 32'h0);
    check("midrun_reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (done === 1'b1) seen = 1'b1;
    end
    check("no_done_after_reset", {31'b0, seen}, 32'd0);

    mthi    = 1'b1;
    mtlo    = 1'b1;
    mt_data = 32'hCAFE_F00D;
    @(negedge CLK);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_both_hi", hi, 32'hCAFE_F00D);
    check("mt_both_lo", lo, 32'hCAFE_F00D);

    // Launch with a simultaneous MTHI: the move must be dropped.
    mthi    = 1'b1;
    mt_data = 32'hFFFF_0000;
    launch(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b1);
    mthi = 1'b0;
    check("start_beats_mthi", hi, 32'hCAFE_F00D);
    run_check(0);
    // Relaunch in the DONE cycle.
    launch(2'b11, 32'd10, 32'd3, 1'b1);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    run_check(0);
    check("b2b_hi", hi, 32'd1);
    check("b2b_lo", lo, 32'd3);
    @(negedge CLK);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      launch(ro, ra, rb, 1'b1);
      run_check(0);
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit owning the HI/LO architectural registers. It sits directly downstream of the register file and consumes its two read ports (rs, rt) as operands for MULT/MULTU/DIV/DIVU. It computes one radix-2 step per cycle and commits the result to HI/LO, which the datapath then reads for MFHI/MFLO. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/HI/LO width (only 32 is required to work)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
CLK  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
start  input  1  launch operation; sampled on posedge
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  32  multiplicand / dividend (register file read_reg1)
rt_data  input  32  multiplier / divisor (register file read_reg2)
mthi  input  1  write mt_data to HI
mtlo  input  1  write mt_data to LO
mt_data  input  32  data for MTHI/MTLO
busy  output  1  iteration in progress; stall MFHI/MFLO/new muldiv
done  output  1  one-cycle pulse when HI/LO have just been committed
hi  output  32  HI register, registered
lo  output  32  LO register, registered

Behaviour:
- Reset (CLK edge with reset=1): state=IDLE; hi=lo=0; busy=0; done=0; counter and working regs cleared. Reset overrides all other inputs, including mid-operation, which aborts the operation with no commit.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE or DONE with start=1: latch op, |rs|, |rt| (abs only for signed ops), result signs, and raw rs/rt. Counter=0. Next state is RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the 32nd step, commit to hi/lo and go to DONE. busy=1 for exactly the 32 cycles in RUN.
- DONE: done=1 and busy=0 for one cycle. Next state is IDLE unless start=1.
- Latency: start sampled at edge E0. hi/lo are valid after edge E32. done is high in the cycle following E32.
- hi/lo hold their previous values throughout RUN. Intermediate values are never visible.
- Multiply: 64-bit product; hi=[63:32], lo=[31:0]. Signed result is the two's complement of the magnitude product when the signs differ.
- Divide: lo=quotient, hi=remainder. For signed division, the quotient truncates toward zero and the remainder takes the sign of the dividend.
- Divide by zero (rt=0, DIV or DIVU): still 32 cycles. Result is hi=rs_data (raw), lo=0xFFFFFFFF. No exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1: ignored, with no effect on the running operation.
- mthi/mtlo when busy=0: the register is written with mt_data at the edge. Both may be asserted together.
- mthi/mtlo while busy=1: ignored.
- Same edge as start (from IDLE/DONE): start wins and mthi/mtlo are dropped. A later commit overwrites HI/LO regardless.
- Back-to-back: start asserted in the DONE cycle is accepted, giving a 33-cycle issue interval.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at E0 -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly 1 cycle after E32.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> hi=0x00000064, lo=0xFFFFFFFF after 32 cycles. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next edge. Start MULTU 3x4, then pulse mtlo=1 and start=1 at cycle 5 of RUN -> both ignored; final hi=0, lo=12.
- Reset asserted on the 10th RUN cycle after prior hi/lo=0xAAAA/0x5555 -> next edge hi=lo=0, busy=0, done never pulses.
- start asserted in the DONE cycle with DIVU 10/3 -> accepted; busy back high next cycle, then lo=3, hi=1.
